// File: rtl/hpdmc_busturn.sv
// ---------------------------------------------------------------------------
// hpdmc_busturn
//
// Data-path timing tracker placed directly after the SDRAM command FSM. It
// watches the READ/WRITE strobes and the one-hot bank of each command. From
// them it produces the qualifiers that gate the FSM's next commands, the DQ
// output-enable window, and the read-data capture strobe for the PHY.
//
// Parameters
//   burst_cycles : sys_clk cycles of data per READ/WRITE (1..4)
//   cnt_width    : width of every timing counter (holds 3+burst_cycles+3)
//
// Ports
//   sys_clk        : system clock, rising edge
//   sdram_rst_n    : asynchronous active-low reset
//   tim_cas        : CAS latency select, 0 = CL2, 1 = CL3
//   tim_wr         : extra write-recovery cycles before precharge (0..3)
//   read, write    : command strobes for this cycle
//   concerned_bank : one-hot bank of the current command
//   read_safe      : a READ may be issued this cycle
//   write_safe     : a WRITE may be issued this cycle
//   precharge_safe : per bank, a PRECHARGE may be issued this cycle
//   direction      : 1 = PHY drives DQ/DM (write data window)
//   direction_r    : direction delayed one cycle
//   rd_valid       : a read data beat is at the PHY capture registers
//   proto_err      : sticky protocol-violation flag (HPDMC_BUSTURN_CHECK_EN)
//
// Optional build macro: HPDMC_BUSTURN_CHECK_EN adds the proto_err output.
//
// Each timing constraint is a down-counter. A constraint is active while its
// counter is nonzero. A new command raises a counter but never lowers it, so
// a later command cannot shorten a constraint that is still pending.
// ---------------------------------------------------------------------------
module hpdmc_busturn #(
    parameter int burst_cycles = 2,
    parameter int cnt_width    = 4
) (
    input  logic       sys_clk,
    input  logic       sdram_rst_n,
    input  logic       tim_cas,
    input  logic [1:0] tim_wr,
    input  logic       read,
    input  logic       write,
    input  logic [3:0] concerned_bank,
    output logic       read_safe,
    output logic       write_safe,
    output logic [3:0] precharge_safe,
    output logic       direction,
    output logic       direction_r,
    output logic       rd_valid
`ifdef HPDMC_BUSTURN_CHECK_EN
    ,
    output logic       proto_err
`endif
);

    localparam logic [cnt_width-1:0] CNT_ZERO   = {cnt_width{1'b0}};
    localparam logic [cnt_width-1:0] CNT_ONE    = cnt_width'(1);
    localparam logic [cnt_width-1:0] BURST      = cnt_width'(burst_cycles);
    localparam logic [cnt_width-1:0] SAME_GAP   = cnt_width'(burst_cycles - 1);
    localparam logic [cnt_width-1:0] WTR_GAP    = cnt_width'(burst_cycles + 1);
    localparam logic [7:0]           BURST_MASK = 8'((1 << burst_cycles) - 1);

    // Next counter value: the natural one-cycle decrement, raised to the new
    // requirement when that is longer.
    function automatic logic [cnt_width-1:0] cnt_merge(
        input logic [cnt_width-1:0] cur,
        input logic [cnt_width-1:0] req
    );
        logic [cnt_width-1:0] dec;
        dec = (cur != CNT_ZERO) ? (cur - CNT_ONE) : CNT_ZERO;
        return (req > dec) ? req : dec;
    endfunction

    logic [cnt_width-1:0] read_cnt_r, write_cnt_r, dir_cnt_r;
    logic [cnt_width-1:0] pre_cnt_r [4];
    logic [7:0]           rd_sr_r;

    logic [cnt_width-1:0] read_cnt_s, write_cnt_s, dir_cnt_s;
    logic [cnt_width-1:0] pre_cnt_s [4];
    logic [7:0]           rd_sr_s;
    logic                 is_wr_s, is_rd_s;
    logic [cnt_width-1:0] cl_s, wr_after_rd_s, pre_after_wr_s;
    logic [7:0]           rd_mask_s;

    // Command decode and the latency values sampled at command time.
    always_comb begin
        // Write wins when both strobes are seen together.
        is_wr_s        = write;
        is_rd_s        = read & ~write;
        cl_s           = cnt_width'(2) + cnt_width'(tim_cas);
        wr_after_rd_s  = cl_s + BURST;
        pre_after_wr_s = BURST + cnt_width'(tim_wr);
        // Read data reaches the capture registers CL cycles after the
        // cycle following the command, for BURST consecutive cycles.
        if (tim_cas) begin
            rd_mask_s = BURST_MASK << 2'd3;
        end else begin
            rd_mask_s = BURST_MASK << 2'd2;
        end
    end

    // Next-state computation for every counter and the read shift register.
    always_comb begin
        read_cnt_s  = cnt_merge(read_cnt_r, CNT_ZERO);
        write_cnt_s = cnt_merge(write_cnt_r, CNT_ZERO);
        dir_cnt_s   = cnt_merge(dir_cnt_r, CNT_ZERO);
        rd_sr_s     = {1'b0, rd_sr_r[7:1]};
        if (is_wr_s) begin
            read_cnt_s  = cnt_merge(read_cnt_r, WTR_GAP);
            write_cnt_s = cnt_merge(write_cnt_r, SAME_GAP);
            dir_cnt_s   = cnt_merge(dir_cnt_r, BURST);
        end else if (is_rd_s) begin
            read_cnt_s  = cnt_merge(read_cnt_r, SAME_GAP);
            write_cnt_s = cnt_merge(write_cnt_r, wr_after_rd_s);
            rd_sr_s     = {1'b0, rd_sr_r[7:1]} | rd_mask_s;
        end else begin
            read_cnt_s  = cnt_merge(read_cnt_r, CNT_ZERO);
        end
        for (int b = 0; b < 4; b++) begin
            if (is_wr_s && concerned_bank[b]) begin
                pre_cnt_s[b] = cnt_merge(pre_cnt_r[b], pre_after_wr_s);
            end else if (is_rd_s && concerned_bank[b]) begin
                pre_cnt_s[b] = cnt_merge(pre_cnt_r[b], BURST);
            end else begin
                pre_cnt_s[b] = cnt_merge(pre_cnt_r[b], CNT_ZERO);
            end
        end
    end

    // Counter, shift-register and direction-delay state.
    always_ff @(posedge sys_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            read_cnt_r  <= CNT_ZERO;
            write_cnt_r <= CNT_ZERO;
            dir_cnt_r   <= CNT_ZERO;
            rd_sr_r     <= 8'h00;
            direction_r <= 1'b0;
            for (int b = 0; b < 4; b++) begin
                pre_cnt_r[b] <= CNT_ZERO;
            end
        end else begin
            read_cnt_r  <= read_cnt_s;
            write_cnt_r <= write_cnt_s;
            dir_cnt_r   <= dir_cnt_s;
            rd_sr_r     <= rd_sr_s;
            direction_r <= direction;
            for (int b = 0; b < 4; b++) begin
                pre_cnt_r[b] <= pre_cnt_s[b];
            end
        end
    end

    // Qualifiers decoded straight from registered state.
    always_comb begin
        read_safe  = (read_cnt_r == CNT_ZERO);
        write_safe = (write_cnt_r == CNT_ZERO);
        direction  = (dir_cnt_r != CNT_ZERO);
        rd_valid   = rd_sr_r[0];
        for (int b = 0; b < 4; b++) begin
            precharge_safe[b] = (pre_cnt_r[b] == CNT_ZERO);
        end
    end

`ifdef HPDMC_BUSTURN_CHECK_EN
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'h0) && ((v & (v - 4'h1)) == 4'h0);
    endfunction

    logic viol_s;

    // Detect any illegal command combination in the current cycle.
    always_comb begin
        viol_s = (read & ~read_safe) | (write & ~write_safe) | (read & write) |
                 ((read | write) & ~is_onehot4(concerned_bank));
    end

    // Sticky error flag, only cleared by reset.
    always_ff @(posedge sys_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            proto_err <= 1'b0;
        end else begin
            proto_err <= proto_err | viol_s;
        end
    end
`endif

endmodule

// File: tb/tb_hpdmc_busturn.sv
module tb_hpdmc_busturn;

    localparam int B   = 2;
    localparam int MAX = 1024;

    logic       sys_clk = 1'b0;
    logic       sdram_rst_n = 1'b0;
    logic       tim_cas = 1'b0;
    logic [1:0] tim_wr = 2'd0;
    logic       read = 1'b0;
    logic       write = 1'b0;
    logic [3:0] concerned_bank = 4'h0;
    logic       read_safe, write_safe, direction, direction_r, rd_valid;
    logic [3:0] precharge_safe;
`ifdef HPDMC_BUSTURN_CHECK_EN
    logic       proto_err;
`endif

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    hpdmc_busturn #(.burst_cycles(B), .cnt_width(4)) dut (
        .sys_clk(sys_clk),
        .sdram_rst_n(sdram_rst_n),
        .tim_cas(tim_cas),
        .tim_wr(tim_wr),
        .read(read),
        .write(write),
        .concerned_bank(concerned_bank),
        .read_safe(read_safe),
        .write_safe(write_safe),
        .precharge_safe(precharge_safe),
        .direction(direction),
        .direction_r(direction_r),
        .rd_valid(rd_valid)
`ifdef HPDMC_BUSTURN_CHECK_EN
        ,
        .proto_err(proto_err)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each resource is blocked up to (and including) a cycle number; the data
    // windows are explicit per-cycle tables.
    int rd_until, wr_until;
    int pre_until [4];
    bit exp_dir [MAX];
    bit exp_rdv [MAX];
    bit exp_err;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_clear();
        rd_until = -1;
        wr_until = -1;
        for (int b = 0; b < 4; b++) pre_until[b] = -1;
        for (int i = 0; i < MAX; i++) begin
            exp_dir[i] = 1'b0;
            exp_rdv[i] = 1'b0;
        end
        exp_err = 1'b0;
    endtask

    initial model_clear();

    // Compare process: every cycle, mid-cycle.
    always @(negedge sys_clk) begin
        int t;
        int cl;
        logic [3:0] e_pre;
        t = cyc;
        if (!sdram_rst_n) begin
            model_clear();
            chk("rst_read_safe", {3'b0, read_safe}, 4'h1);
            chk("rst_write_safe", {3'b0, write_safe}, 4'h1);
            chk("rst_precharge_safe", precharge_safe, 4'hF);
            chk("rst_direction", {3'b0, direction}, 4'h0);
            chk("rst_direction_r", {3'b0, direction_r}, 4'h0);
            chk("rst_rd_valid", {3'b0, rd_valid}, 4'h0);
        end else begin
            for (int b = 0; b < 4; b++) e_pre[b] = (t > pre_until[b]);
            chk("read_safe", {3'b0, read_safe}, {3'b0, t > rd_until});
            chk("write_safe", {3'b0, write_safe}, {3'b0, t > wr_until});
            chk("precharge_safe", precharge_safe, e_pre);
            chk("direction", {3'b0, direction}, {3'b0, exp_dir[t]});
            chk("direction_r", {3'b0, direction_r}, {3'b0, exp_dir[t-1]});
            chk("rd_valid", {3'b0, rd_valid}, {3'b0, exp_rdv[t]});
`ifdef HPDMC_BUSTURN_CHECK_EN
            chk("proto_err", {3'b0, proto_err}, {3'b0, exp_err});
            if ((read && t <= rd_until) || (write && t <= wr_until) || (read && write) ||
                ((read || write) && $countones(concerned_bank) != 1))
                exp_err = 1'b1;
`endif
            cl = 2 + int'(tim_cas);
            if (write) begin
                wr_until = imax(wr_until, t + B - 1);
                rd_until = imax(rd_until, t + B + 1);
                for (int b = 0; b < 4; b++)
                    if (concerned_bank[b]) pre_until[b] = imax(pre_until[b], t + B + int'(tim_wr));
                for (int k = 1; k <= B; k++) exp_dir[t + k] = 1'b1;
            end else if (read) begin
                rd_until = imax(rd_until, t + B - 1);
                wr_until = imax(wr_until, t + cl + B);
                for (int b = 0; b < 4; b++)
                    if (concerned_bank[b]) pre_until[b] = imax(pre_until[b], t + B);
                for (int k = 1; k <= B; k++) exp_rdv[t + cl + k] = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Drive a command for the current cycle; returns one cycle later (+1).
    task automatic cmd(input logic r, input logic w, input logic [3:0] bank,
                       input logic cas, input logic [1:0] twr);
        read = r; write = w; concerned_bank = bank; tim_cas = cas; tim_wr = twr;
        @(posedge sys_clk); #1;
        read = 1'b0; write = 1'b0; concerned_bank = 4'h0;
    endtask

    // Move to posedge+1 of cycle c.
    task automatic go_cycle(input int c);
        while (cyc < c) begin
            @(posedge sys_clk); #1;
        end
    endtask

    // Move to the negedge inside cycle c (c must lie ahead).
    task automatic smp(input int c);
        do @(negedge sys_clk); while (cyc < c);
    endtask

    task automatic pulse_reset();
        @(posedge sys_clk); #3;
        sdram_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1 sdram_rst_n = 1'b1;
    endtask

    initial begin
        int t;
        repeat (3) @(posedge sys_clk);
        #1 sdram_rst_n = 1'b1;

        // Idle after reset.
        t = cyc;
        smp(t + 19);
        chk("idle_read_safe", {3'b0, read_safe}, 4'h1);
        chk("idle_precharge", precharge_safe, 4'hF);

        // READ bank1, CL2.
        go_cycle(t + 25); t = cyc;
        cmd(1'b1, 1'b0, 4'b0010, 1'b0, 2'd0);
        smp(t + 1); chk("rd_rs_low", {3'b0, read_safe}, 4'h0);
                    chk("rd_pre", precharge_safe, 4'b1101);
        smp(t + 2); chk("rd_rs_high", {3'b0, read_safe}, 4'h1);
                    chk("rd_pre2", precharge_safe, 4'b1101);
        smp(t + 3); chk("rd_rdv_on", {3'b0, rd_valid}, 4'h1);
                    chk("rd_pre_free", precharge_safe, 4'hF);
        smp(t + 4); chk("rd_ws_low", {3'b0, write_safe}, 4'h0);
        smp(t + 5); chk("rd_ws_high", {3'b0, write_safe}, 4'h1);
                    chk("rd_rdv_off", {3'b0, rd_valid}, 4'h0);

        // WRITE bank0, tim_wr=2.
        go_cycle(t + 10); t = cyc;
        cmd(1'b0, 1'b1, 4'b0001, 1'b0, 2'd2);
        tim_wr = 2'd0;
        smp(t + 1); chk("wr_dir_on", {3'b0, direction}, 4'h1);
        smp(t + 3); chk("wr_dir_off", {3'b0, direction}, 4'h0);
                    chk("wr_dirr_on", {3'b0, direction_r}, 4'h1);
                    chk("wr_rs_low", {3'b0, read_safe}, 4'h0);
        smp(t + 4); chk("wr_pre_low", precharge_safe, 4'b1110);
                    chk("wr_rs_high", {3'b0, read_safe}, 4'h1);
        smp(t + 5); chk("wr_pre_high", precharge_safe, 4'hF);

        // Overlapping READs, CL3; cas changes after the first.
        go_cycle(t + 10); t = cyc;
        cmd(1'b1, 1'b0, 4'b0100, 1'b1, 2'd0);
        tim_cas = 1'b0;
        go_cycle(t + 2);
        cmd(1'b1, 1'b0, 4'b0100, 1'b1, 2'd0);
        smp(t + 4); chk("rr_rdv_first", {3'b0, rd_valid}, 4'h1);
        smp(t + 7); chk("rr_rdv_last", {3'b0, rd_valid}, 4'h1);
                    chk("rr_ws_low", {3'b0, write_safe}, 4'h0);
        smp(t + 8); chk("rr_rdv_off", {3'b0, rd_valid}, 4'h0);
                    chk("rr_ws_high", {3'b0, write_safe}, 4'h1);

        // WRITE bank0 tim_wr=3 then READ bank0: read neither shortens nor extends.
        go_cycle(t + 12); t = cyc;
        cmd(1'b0, 1'b1, 4'b0001, 1'b0, 2'd3);
        go_cycle(t + 3);
        cmd(1'b1, 1'b0, 4'b0001, 1'b0, 2'd0);
        smp(t + 5); chk("max_pre_low", precharge_safe, 4'b1110);
        smp(t + 6); chk("max_pre_high", precharge_safe, 4'hF);

        // Back-to-back writes, then a READ inside tWTR (violation).
        go_cycle(t + 12); t = cyc;
        cmd(1'b0, 1'b1, 4'b1000, 1'b0, 2'd1);
        cmd(1'b0, 1'b1, 4'b1000, 1'b0, 2'd1);
        cmd(1'b1, 1'b0, 4'b1000, 1'b0, 2'd0);
        smp(t + 3); chk("bb_dir_cont", {3'b0, direction}, 4'h1);
`ifdef HPDMC_BUSTURN_CHECK_EN
        smp(t + 4); chk("perr_set", {3'b0, proto_err}, 4'h1);
        smp(t + 20); chk("perr_sticky", {3'b0, proto_err}, 4'h1);
`endif

        // Simultaneous read/write to two banks; then a zero-bank read.
        go_cycle(t + 25); t = cyc;
        cmd(1'b1, 1'b1, 4'b0110, 1'b1, 2'd1);
        smp(t + 1); chk("rw_dir", {3'b0, direction}, 4'h1);
                    chk("rw_pre", precharge_safe, 4'b1001);
        smp(t + 4); chk("rw_no_rdv", {3'b0, rd_valid}, 4'h0);
        go_cycle(t + 10); t = cyc;
        cmd(1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
        smp(t + 1); chk("nob_pre", precharge_safe, 4'hF);

        // Reset mid-window: outputs must return asynchronously.
        go_cycle(t + 10); t = cyc;
        cmd(1'b0, 1'b1, 4'b1111, 1'b0, 2'd3);
        #2 sdram_rst_n = 1'b0;
        #1 chk("arst_dir", {3'b0, direction}, 4'h0);
           chk("arst_pre", precharge_safe, 4'hF);
           chk("arst_rs", {3'b0, read_safe}, 4'h1);
        @(posedge sys_clk); @(posedge sys_clk); #1 sdram_rst_n = 1'b1;
`ifdef HPDMC_BUSTURN_CHECK_EN
        smp(cyc + 1); chk("perr_cleared", {3'b0, proto_err}, 4'h0);
`endif

        // Mixed command stream checked by the model.
        go_cycle(cyc + 3);
        for (int i = 0; i < 150; i++) begin
            int r;
            r = $urandom_range(0, 5);
            cmd(r == 0 || r == 5, r == 1 || r == 5, 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            if (i == 75) pulse_reset();
        end
        smp(cyc + 12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
